egress_scheduler: RTL and testbench

- Frame-granular crossbar scheduler placed after NUM_INGRESS ingress_filter instances.
- Routes each filtered frame to the egress port selected by its tdest.
- Arbitrates round-robin among ingress filters contending for the same egress port.
- Holds a grant for a whole frame, from the first beat through the tlast beat, so frames never interleave on an egress port.

---
 rtl/egress_scheduler_pkg.sv | 23 ++
 rtl/egress_scheduler_rr_arbiter.sv | 31 +++
 rtl/egress_scheduler.sv | 127 ++++++++++++
 tb/tb_egress_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_scheduler_pkg.sv
// rtl/egress_scheduler_pkg.sv - shared stream types and FSM states for the egress scheduler
package egress_scheduler_pkg;

  localparam int TDEST_W = 2;
  localparam int TDATA_W = 16;

  typedef struct packed {
    logic               tvalid;
    logic [TDATA_W-1:0] tdata;
    logic [TDEST_W-1:0] tdest;
    logic               tlast;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } egress_state_e;

endpackage

// File: rtl/egress_scheduler_rr_arbiter.sv
// rtl/egress_scheduler_rr_arbiter.sv - combinational round-robin pick, one per egress port
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // First requester at or after ptr wins; then wrap around to the ones below ptr
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/egress_scheduler.sv
// rtl/egress_scheduler.sv - frame-granular crossbar routing ingress streams to egress ports by tdest
module egress_scheduler
  import egress_scheduler_pkg::*;
#(
  parameter int NUM_INGRESS = 4,
  parameter int NUM_EGRESS  = 4,
  parameter int CTR_WIDTH   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  axis_d_source_t [NUM_INGRESS-1:0]      ingress_source,
  output axis_d_sink_t   [NUM_INGRESS-1:0]      ingress_sink,
  output axis_d_source_t [NUM_EGRESS-1:0]       egress_source,
  input  axis_d_sink_t   [NUM_EGRESS-1:0]       egress_sink,
  output logic [NUM_EGRESS-1:0]                 busy,
  output logic [NUM_EGRESS-1:0][CTR_WIDTH-1:0]  frame_count
);

  localparam int IDX_W = $clog2(NUM_INGRESS);

  egress_state_e state_q [NUM_EGRESS];
  egress_state_e state_d [NUM_EGRESS];
  logic [NUM_EGRESS-1:0][IDX_W-1:0]     grant_q, grant_d;
  logic [NUM_EGRESS-1:0][IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_EGRESS-1:0][CTR_WIDTH-1:0] frame_count_q, frame_count_d;

  logic [NUM_INGRESS-1:0]                 src_held;
  logic [NUM_EGRESS-1:0][NUM_INGRESS-1:0] req;
  logic [NUM_EGRESS-1:0][NUM_INGRESS-1:0] arb_gnt;
  logic [NUM_EGRESS-1:0][IDX_W-1:0]       arb_idx;
  logic [NUM_EGRESS-1:0]                  beat_last;

  // A source already owned by an egress cannot request again until its tlast beat
  always_comb begin
    src_held = '0;
    req      = '0;
    for (int e = 0; e < NUM_EGRESS; e++) begin
      if (state_q[e] == LOCKED) src_held[grant_q[e]] = 1'b1;
    end
    for (int e = 0; e < NUM_EGRESS; e++) begin
      for (int i = 0; i < NUM_INGRESS; i++) begin
        req[e][i] = ingress_source[i].tvalid &&
                    (ingress_source[i].tdest == TDEST_W'(e)) &&
                    !src_held[i];
      end
    end
  end

  for (genvar e = 0; e < NUM_EGRESS; e++) begin : g_arb
    rr_arbiter #(
      .N  (NUM_INGRESS),
      .PW (IDX_W)
    ) u_rr_arbiter (
      .req (req[e]),
      .ptr (ptr_q[e]),
      .gnt (arb_gnt[e])
    );
  end

  // Locked ports are a straight wire from the granted source; tready flows back the same way
  always_comb begin
    egress_source = '0;
    ingress_sink  = '0;
    busy          = '0;
    beat_last     = '0;
    for (int e = 0; e < NUM_EGRESS; e++) begin
      if (state_q[e] == LOCKED) begin
        busy[e]                          = 1'b1;
        egress_source[e]                 = ingress_source[grant_q[e]];
        ingress_sink[grant_q[e]].tready  = egress_sink[e].tready;
        beat_last[e] = ingress_source[grant_q[e]].tvalid &&
                       ingress_source[grant_q[e]].tlast &&
                       egress_sink[e].tready;
      end
    end
  end

  // Per-egress FSM: grant on a registered pick, release after the tlast beat
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    frame_count_d = frame_count_q;
    arb_idx       = '0;
    for (int e = 0; e < NUM_EGRESS; e++) begin
      for (int i = 0; i < NUM_INGRESS; i++) begin
        if (arb_gnt[e][i]) arb_idx[e] = IDX_W'(i);
      end
      case (state_q[e])
        IDLE: begin
          if (en && (|req[e])) begin
            state_d[e] = LOCKED;
            grant_d[e] = arb_idx[e];
          end
        end
        LOCKED: begin
          if (beat_last[e]) begin
            state_d[e]       = IDLE;
            ptr_d[e]         = (grant_q[e] == IDX_W'(NUM_INGRESS - 1)) ? '0
                                                                       : grant_q[e] + IDX_W'(1);
            frame_count_d[e] = frame_count_q[e] + CTR_WIDTH'(1);
          end
        end
        default: state_d[e] = IDLE;
      endcase
    end
  end

  // State, grant, pointer and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < NUM_EGRESS; e++) state_q[e] <= IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_egress_scheduler.sv
// tb/tb_egress_scheduler.sv - directed-vector bench for egress_scheduler
module tb_egress_scheduler;
  import egress_scheduler_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b1;

  axis_d_source_t       src [4];
  axis_d_source_t [3:0] ingress_source;
  axis_d_sink_t   [3:0] ingress_sink;
  axis_d_source_t [3:0] egress_source;
  axis_d_sink_t   [3:0] egress_sink;
  logic [3:0]           busy;
  logic [3:0][31:0]     frame_count;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n0;

  logic [15:0] log_d [4][$];
  int          log_c [4][$];

  logic [0:12] rdy_tab = 13'b1101011111111;
  logic [0:12] en_tab  = 13'b1100000000111;

  egress_scheduler #(
    .NUM_INGRESS (4),
    .NUM_EGRESS  (4),
    .CTR_WIDTH   (32)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .ingress_source (ingress_source),
    .ingress_sink   (ingress_sink),
    .egress_source  (egress_source),
    .egress_sink    (egress_sink),
    .busy           (busy),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 4; i++) ingress_source[i] = src[i];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Record every transferred egress beat with its cycle number
  always @(negedge clk) begin
    if (reset) begin
      for (int e = 0; e < 4; e++) begin
        if (egress_source[e].tvalid && egress_sink[e].tready) begin
          log_d[e].push_back(egress_source[e].tdata);
          log_c[e].push_back(cyc);
          chk("egress_tdest", 128'(egress_source[e].tdest), 128'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int e = 0; e < 4; e++) begin
      log_d[e].delete();
      log_c[e].delete();
    end
  endtask

  task automatic chk_beat(input int e, input int j, input logic [15:0] d, input int c);
    if (j < log_d[e].size()) begin
      chk("beat_data", 128'(log_d[e][j]), 128'(d));
      chk("beat_cycle", 128'(log_c[e][j]), 128'(c));
    end else begin
      chk("beat_count", 128'(log_d[e].size()), 128'(j + 1));
    end
  endtask

  task automatic send_frame(input int i, input int dest, input int nb, input logic [15:0] base);
    for (int b = 0; b < nb; b++) begin
      int t;
      src[i].tvalid = 1'b1;
      src[i].tdata  = 16'(base + 16'(b));
      src[i].tdest  = 2'(dest);
      src[i].tlast  = (b == nb - 1);
      t = 0;
      @(negedge clk);
      while (!ingress_sink[i].tready && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("src_ready", 128'(ingress_sink[i].tready), 128'(1));
      @(posedge clk);
      #1;
    end
    src[i] = '0;
  endtask

  task automatic send_n(input int i);
    for (int f = 0; f < 4; f++) send_frame(i, 0, 2, {4'(i), 4'(f), 8'h00});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src[i]                = '0;
      egress_sink[i].tready = 1'b1;
    end
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_egress", 128'(egress_source), 128'(0));
    chk("rst_ingress_ready", 128'(ingress_sink), 128'(0));
    chk("rst_count", 128'(frame_count), 128'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // single frame ingress 1 -> egress 2
    n0 = cyc;
    send_frame(1, 2, 3, 16'hA001);
    repeat (2) step();
    chk("t1_len", 128'(log_d[2].size()), 128'(3));
    chk_beat(2, 0, 16'hA001, n0 + 1);
    chk_beat(2, 1, 16'hA002, n0 + 2);
    chk_beat(2, 2, 16'hA003, n0 + 3);
    chk("t1_other_ports", 128'(log_d[0].size() + log_d[1].size() + log_d[3].size()), 128'(0));
    chk("t1_count2", 128'(frame_count[2]), 128'(1));
    chk("t1_busy", 128'(busy), 128'(0));
    clear_logs();

    // contention on egress 1 between ingress 0 and 3
    n0 = cyc;
    fork
      send_frame(0, 1, 2, 16'hB001);
      send_frame(3, 1, 2, 16'hB301);
      begin
        @(negedge clk);
        chk("t2_rdy3_req", 128'(ingress_sink[3].tready), 128'(0));
        @(negedge clk);
        chk("t2_rdy3_b0", 128'(ingress_sink[3].tready), 128'(0));
        chk("t2_rdy0_b0", 128'(ingress_sink[0].tready), 128'(1));
        @(negedge clk);
        chk("t2_rdy3_b1", 128'(ingress_sink[3].tready), 128'(0));
        @(negedge clk);
        chk("t2_rdy3_idle", 128'(ingress_sink[3].tready), 128'(0));
        chk("t2_idle_valid", 128'(egress_source[1].tvalid), 128'(0));
        @(negedge clk);
        chk("t2_rdy3_grant", 128'(ingress_sink[3].tready), 128'(1));
      end
    join
    repeat (2) step();
    chk_beat(1, 0, 16'hB001, n0 + 1);
    chk_beat(1, 1, 16'hB002, n0 + 2);
    chk_beat(1, 2, 16'hB301, n0 + 4);
    chk_beat(1, 3, 16'hB302, n0 + 5);
    chk("t2_count1", 128'(frame_count[1]), 128'(2));
    clear_logs();

    // fairness: four sources, four two-beat frames each, all to egress 0
    n0 = cyc;
    fork
      send_n(0);
      send_n(1);
      send_n(2);
      send_n(3);
    join
    repeat (2) step();
    chk("t3_len", 128'(log_d[0].size()), 128'(32));
    for (int j = 0; j < 32; j++) begin
      int k;
      logic [15:0] exp_d;
      k     = j / 2;
      exp_d = {4'(k % 4), 4'(k / 4), 8'(j % 2)};
      chk_beat(0, j, exp_d, n0 + 1 + 3 * k + (j % 2));
    end
    chk("t3_count0", 128'(frame_count[0]), 128'(16));
    clear_logs();

    // parallel paths ingress 0 -> egress 0 and ingress 1 -> egress 3
    n0 = cyc;
    fork
      send_frame(0, 0, 4, 16'hC001);
      send_frame(1, 3, 4, 16'hD101);
      begin
        repeat (3) @(negedge clk);
        chk("t4_busy", 128'(busy), 128'(4'b1001));
      end
    join
    repeat (2) step();
    for (int b = 0; b < 4; b++) begin
      chk_beat(0, b, 16'(16'hC001 + b), n0 + 1 + b);
      chk_beat(3, b, 16'(16'hD101 + b), n0 + 1 + b);
    end
    chk("t4_count0", 128'(frame_count[0]), 128'(17));
    chk("t4_count3", 128'(frame_count[3]), 128'(1));
    clear_logs();

    // backpressure on egress 2 with en dropped mid-frame; ingress 3 waits for en
    n0 = cyc;
    fork
      send_frame(2, 2, 4, 16'hE201);
      send_frame(3, 2, 2, 16'hF301);
      begin
        for (int k = 0; k < 13; k++) begin
          egress_sink[2].tready = rdy_tab[k];
          en                    = en_tab[k];
          @(negedge clk);
          if (k == 8) begin
            chk("t5_hold_busy", 128'(busy[2]), 128'(0));
            chk("t5_hold_rdy3", 128'(ingress_sink[3].tready), 128'(0));
          end
          @(posedge clk);
          #1;
        end
        egress_sink[2].tready = 1'b1;
        en                    = 1'b1;
      end
    join
    repeat (2) step();
    chk("t5_len", 128'(log_d[2].size()), 128'(6));
    chk_beat(2, 0, 16'hE201, n0 + 1);
    chk_beat(2, 1, 16'hE202, n0 + 3);
    chk_beat(2, 2, 16'hE203, n0 + 5);
    chk_beat(2, 3, 16'hE204, n0 + 6);
    chk_beat(2, 4, 16'hF301, n0 + 11);
    chk_beat(2, 5, 16'hF302, n0 + 12);
    chk("t5_count2", 128'(frame_count[2]), 128'(3));
    clear_logs();

    // reset asserted during beat 2 of a 5-beat frame
    n0 = cyc;
    src[2].tvalid = 1'b1;
    src[2].tdata  = 16'h7201;
    src[2].tdest  = 2'd1;
    src[2].tlast  = 1'b0;
    step();
    step();
    src[2].tdata = 16'h7202;
    #1 reset = 1'b0;
    step();
    @(negedge clk);
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_egress", 128'(egress_source), 128'(0));
    chk("t6_ingress_ready", 128'(ingress_sink), 128'(0));
    chk("t6_count", 128'(frame_count), 128'(0));
    chk("t6_partial_len", 128'(log_d[1].size()), 128'(1));
    chk_beat(1, 0, 16'h7201, n0 + 1);
    src[2] = '0;
    step();
    reset = 1'b1;
    step();
    clear_logs();
    n0 = cyc;
    send_frame(2, 1, 2, 16'h8201);
    repeat (2) step();
    chk_beat(1, 0, 16'h8201, n0 + 1);
    chk_beat(1, 1, 16'h8202, n0 + 2);
    chk("t6_count1", 128'(frame_count[1]), 128'(1));
    chk("t6_count2", 128'(frame_count[2]), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
